// File: rtl/jtkiwi_tile_pkg.sv
// Shared definitions for the SETA-style column-scrolled tile layer:
// sequencer states, tile geometry and tilemap address packing.
package jtkiwi_tile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam int         TILE_W    = 16;
  localparam int         TM_AW     = 12;
  localparam int         COL_AW    = 8;
  localparam logic [8:0] VLAST_DEF = 9'hF0;

  // Tilemap word address: {page, bank=1, attr/code select, h[8:5], v[7:4], h[4]}
  function automatic logic [TM_AW-1:0] tm_pack(
    input logic       page,
    input logic       attr_sel,
    input logic [4:0] eff_h_hi,
    input logic [3:0] eff_v_row
  );
    return {page, 1'b1, attr_sel, eff_h_hi[4:1], eff_v_row, eff_h_hi[0]};
  endfunction

endpackage

// File: rtl/jtkiwi_cor_linebuf.sv
// Ping-pong pixel line buffer: the draw engine fills one half while the
// other half is displayed and wiped cell by cell as it is read.
module jtkiwi_cor_linebuf #(
  parameter int PW     = 9,
  parameter bit TRANSP = 1'b1,
  parameter bit CLRRD  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          line,
  input  logic [8:0]    buf_addr,
  input  logic          buf_we,
  input  logic [PW-1:0] buf_din,
  input  logic [8:0]    hdump,
  input  logic          pxl_cen,
  output logic [PW-1:0] pxl
);
  import jtkiwi_tile_pkg::*;

  logic [PW-1:0] mem [0:1023];
  logic [PW-1:0] pxl_q;
  logic [9:0]    wr_addr;
  logic [9:0]    rd_addr;
  logic          wr_en;

  always_comb begin
    wr_addr = {line, buf_addr};
    rd_addr = {~line, hdump};
    wr_en   = buf_we & ~(TRANSP && (buf_din[3:0] == 4'd0));
  end

  // Both ports touch opposite halves, so the clear never races a draw write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= buf_din;
    if (CLRRD && pxl_cen) mem[rd_addr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pxl_q <= '0;
    else if (pxl_cen) pxl_q <= mem[rd_addr];
  end

  assign pxl = pxl_q;

endmodule

// File: rtl/jtkiwi_coltile.sv
// Column-scrolled tilemap sequencer: per line it fetches scroll and tile
// data for each 16-px column and hands draw requests to a tile engine.
module jtkiwi_coltile
  import jtkiwi_tile_pkg::*;
#(
  parameter int         CW     = 5,
  parameter int         PW     = 9,
  parameter logic [8:0] VLAST  = VLAST_DEF,
  parameter bit         TRANSP = 1'b1,
  parameter bit         CLRRD  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tm_cen,
  input  logic                      pxl_cen,
  input  logic                      hs,
  input  logic                      page,
  input  logic [(1<<(CW-1))-1:0]    col_xmsb,
  input  logic [3:0]                col_cfg,
  input  logic [1:0]                col0,
  input  logic [8:0]                vrender,
  input  logic [8:0]                hdump,
  output logic [TM_AW-1:0]          tm_addr,
  input  logic [15:0]               tm_data,
  output logic [COL_AW-1:0]         col_addr,
  input  logic [7:0]                col_data,
  output logic                      dr_draw,
  input  logic                      dr_busy,
  output logic                      dr_abort,
  output logic [15:0]               dr_code,
  output logic [15:0]               dr_attr,
  output logic [8:0]                dr_xpos,
  output logic [3:0]                dr_ysub,
  input  logic [8:0]                buf_addr,
  input  logic                      buf_we,
  input  logic [PW-1:0]             buf_din,
  output logic [PW-1:0]             pxl,
  output logic                      done,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  seq_state_t    state_q,   state_d;
  logic          hsl_q,     hsl_d;
  logic          line_q,    line_d;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [CW-2:0] col_end_q, col_end_d;
  logic [1:0]    st_q,      st_d;
  logic [7:0]    yscr_q,    yscr_d;
  logic [8:0]    xscr_q,    xscr_d;
  logic [15:0]   code_q,    code_d;
  logic          dr_draw_q, dr_draw_d;
  logic          dr_abort_q, dr_abort_d;
  logic [15:0]   dr_code_q, dr_code_d;
  logic [15:0]   dr_attr_q, dr_attr_d;
  logic [8:0]    dr_xpos_q, dr_xpos_d;
  logic [3:0]    dr_ysub_q, dr_ysub_d;
  logic          done_q,    done_d;
  logic          ovf_q,     ovf_d;

  logic          hs_edge;
  logic          running;
  logic          last_col;
  logic [CW-2:0] pair;
  logic [CW-1:0] col_sum;
  logic [4:0]    eff_h_hi;
  logic [7:0]    eff_v;
  logic [CW+2:0] col_addr_w;

  always_comb begin
    hs_edge  = hs & ~hsl_q;
    running  = (state_q == RUN);
    pair     = col_cnt_q[CW-1:1];
    last_col = (pair == col_end_q) & col_cnt_q[0];
    eff_v    = vrender[7:0] + yscr_q;
    col_sum  = col_cnt_q + CW'({col0, 3'b000});
    // The low nibble of the column position is zero, so only bits [8:4] carry.
    eff_h_hi = 5'(col_sum) + xscr_q[8:4];
    col_addr_w = {pair, 1'b0, st_q[0], 2'b00};
    col_addr = running ? COL_AW'(col_addr_w) : '0;
    tm_addr  = running ? tm_pack(page, st_q[0], eff_h_hi, eff_v[7:4]) : '0;
  end

  always_comb begin
    state_d    = state_q;
    hsl_d      = hs;
    line_d     = line_q;
    col_cnt_d  = col_cnt_q;
    col_end_d  = col_end_q;
    st_d       = st_q;
    yscr_d     = yscr_q;
    xscr_d     = xscr_q;
    code_d     = code_q;
    dr_draw_d  = 1'b0;
    dr_abort_d = 1'b0;
    dr_code_d  = dr_code_q;
    dr_attr_d  = dr_attr_q;
    dr_xpos_d  = dr_xpos_q;
    dr_ysub_d  = dr_ysub_q;
    done_d     = done_q;
    ovf_d      = ovf_q & ~ovf_clr;

    if (hs_edge) begin
      line_d    = ~line_q;
      col_cnt_d = '0;
      st_d      = 2'd0;
      col_end_d = (col_cfg == 4'd1) ? '1 : (CW-1)'(col_cfg - 4'd1);
      if (running && !done_q) begin
        dr_abort_d = 1'b1;
        ovf_d      = 1'b1;
      end
      if (vrender <= VLAST && col_cfg != 4'd0) begin
        state_d = RUN;
        done_d  = 1'b0;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (running && tm_cen) begin
      case (st_q)
        2'd0: begin
          yscr_d = col_data;
          st_d   = 2'd1;
        end
        2'd1: begin
          xscr_d = {col_xmsb[pair], col_data};
          st_d   = 2'd2;
        end
        2'd2: begin
          code_d = tm_data;
          st_d   = 2'd3;
        end
        default: begin
          if (!dr_busy) begin
            dr_draw_d = 1'b1;
            dr_code_d = code_q;
            dr_attr_d = tm_data;
            dr_xpos_d = 9'({col_cnt_q, 4'b0000}) - {5'd0, xscr_q[3:0]};
            dr_ysub_d = eff_v[3:0];
            col_cnt_d = col_cnt_q + 1'b1;
            st_d      = 2'd0;
            done_d    = last_col;
            if (last_col) state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hsl_q      <= 1'b0;
      line_q     <= 1'b0;
      col_cnt_q  <= '0;
      col_end_q  <= '0;
      st_q       <= 2'd0;
      yscr_q     <= '0;
      xscr_q     <= '0;
      code_q     <= '0;
      dr_draw_q  <= 1'b0;
      dr_abort_q <= 1'b0;
      dr_code_q  <= '0;
      dr_attr_q  <= '0;
      dr_xpos_q  <= '0;
      dr_ysub_q  <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hsl_q      <= hsl_d;
      line_q     <= line_d;
      col_cnt_q  <= col_cnt_d;
      col_end_q  <= col_end_d;
      st_q       <= st_d;
      yscr_q     <= yscr_d;
      xscr_q     <= xscr_d;
      code_q     <= code_d;
      dr_draw_q  <= dr_draw_d;
      dr_abort_q <= dr_abort_d;
      dr_code_q  <= dr_code_d;
      dr_attr_q  <= dr_attr_d;
      dr_xpos_q  <= dr_xpos_d;
      dr_ysub_q  <= dr_ysub_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign dr_draw  = dr_draw_q;
  assign dr_abort = dr_abort_q;
  assign dr_code  = dr_code_q;
  assign dr_attr  = dr_attr_q;
  assign dr_xpos  = dr_xpos_q;
  assign dr_ysub  = dr_ysub_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

  jtkiwi_cor_linebuf #(
    .PW     (PW),
    .TRANSP (TRANSP),
    .CLRRD  (CLRRD)
  ) u_linebuf (
    .clk      (clk),
    .rst      (rst),
    .line     (line_q),
    .buf_addr (buf_addr),
    .buf_we   (buf_we),
    .buf_din  (buf_din),
    .hdump    (hdump),
    .pxl_cen  (pxl_cen),
    .pxl      (pxl)
  );

endmodule
